// File: rtl/data_memory.sv
// Single-port word memory: combinational read, rising-edge write, and an
// asynchronous active-low reset that clears every word at once.
module data_memory #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] data_a,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [WIDTH-1:0]  data_b,
  output logic [WIDTH-1:0]  data_out
);

  // One extra bit so DEPTH == 2**ADDR_W is representable in the compare.
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_core [0:DEPTH-1];
  logic             in_range;

  assign in_range = ({1'b0, data_a} < DEPTH_EXT);

  // Each word has its own enable so an unknown address or enable in
  // simulation evaluates false everywhere and leaves every word untouched.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic word_we;

      assign word_we = mem_write && in_range && (data_a == ADDR_W'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          mem_core[gi] <= '0;
        end else if (word_we) begin
          mem_core[gi] <= data_b;
        end
      end
    end
  endgenerate

  // No bypass: a same-address write shows up only after the edge.
  always_comb begin
    data_out = '0;
    if (mem_read && in_range) begin
      data_out = mem_core[data_a];
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: a full-depth instance plus a DEPTH=200
// instance for out-of-range behaviour.
module tb_data_memory;

  logic       clk;
  logic       reset;
  logic [7:0] data_a;
  logic       mem_read;
  logic       mem_write;
  logic [7:0] data_b;
  logic [7:0] data_out;

  logic [7:0] data_a2;
  logic       mem_read2;
  logic       mem_write2;
  logic [7:0] data_b2;
  logic [7:0] data_out2;

  int checks;
  int errors;

  data_memory #(.WIDTH(8), .ADDR_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .data_a   (data_a),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .data_b   (data_b),
    .data_out (data_out)
  );

  data_memory #(.WIDTH(8), .ADDR_W(8), .DEPTH(200)) dut200 (
    .clk      (clk),
    .reset    (reset),
    .data_a   (data_a2),
    .mem_read (mem_read2),
    .mem_write(mem_write2),
    .data_b   (data_b2),
    .data_out (data_out2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus only: one write to the full-depth instance on the next edge.
  task automatic do_write(input logic [7:0] addr, input logic [7:0] val);
    @(negedge clk);
    data_a    = addr;
    data_b    = val;
    mem_write = 1'b1;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic do_write2(input logic [7:0] addr, input logic [7:0] val);
    @(negedge clk);
    data_a2    = addr;
    data_b2    = val;
    mem_write2 = 1'b1;
    @(posedge clk);
    #1;
    mem_write2 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b0;
    mem_read = 1'b1;
    for (int a = 0; a < 256; a++) begin
      data_a = 8'(a);
      #1;
      checks++;
      if (data_out !== 8'h00) begin
        errors++;
        $display("FAIL reset_sweep addr=%0d got=%h exp=00", a, data_out);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    $display("test_reset: swept 256 addresses");
  endtask

  task automatic test_write_readback;
    do_write(8'd4, 8'hA5);
    do_write(8'd5, 8'h3C);
    mem_read = 1'b1;
    data_a = 8'd4; #1;
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL readback_4 got=%h exp=a5", data_out);
    end
    data_a = 8'd5; #1;
    checks++;
    if (data_out !== 8'h3C) begin
      errors++; $display("FAIL readback_5 got=%h exp=3c", data_out);
    end
    data_a = 8'd6; #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL untouched_6 got=%h exp=00", data_out);
    end
    $display("test_write_readback: addr4/5 written, addr6 checked");
  endtask

  task automatic test_write_disabled;
    @(negedge clk);
    data_a = 8'd8; data_b = 8'hEE; mem_write = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL no_write_when_disabled got=%h exp=00", data_out);
    end
    $display("test_write_disabled: addr8 with mem_write=0");
  endtask

  task automatic test_backdoor;
    @(negedge clk);
    dut.mem_core[6] = 8'h7F;
    dut.mem_core[7] = 8'hFF;
    data_a = 8'd6; #1;
    checks++;
    if (data_out !== 8'h7F) begin
      errors++; $display("FAIL backdoor_6 got=%h exp=7f", data_out);
    end
    data_a = 8'd7; #1;
    checks++;
    if (data_out !== 8'hFF) begin
      errors++; $display("FAIL backdoor_7 got=%h exp=ff", data_out);
    end
    @(posedge clk); #1;
    checks++;
    if (data_out !== 8'hFF) begin
      errors++; $display("FAIL backdoor_persist got=%h exp=ff", data_out);
    end
    $display("test_backdoor: deposited 6=7f 7=ff");
  endtask

  task automatic test_read_during_write;
    do_write(8'd10, 8'h11);
    @(negedge clk);
    data_a = 8'd10; data_b = 8'h22; mem_write = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h11) begin
      errors++; $display("FAIL rdw_before_edge got=%h exp=11", data_out);
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
    checks++;
    if (data_out !== 8'h22) begin
      errors++; $display("FAIL rdw_after_edge got=%h exp=22", data_out);
    end
    $display("test_read_during_write: addr10 11->22");
  endtask

  task automatic test_write_with_read_off;
    @(negedge clk);
    mem_read = 1'b0;
    data_a = 8'd12; data_b = 8'h5E; mem_write = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL read_disabled got=%h exp=00", data_out);
    end
    @(posedge clk); #1;
    mem_write = 1'b0;
    mem_read = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h5E) begin
      errors++; $display("FAIL write_with_read_off got=%h exp=5e", data_out);
    end
    $display("test_write_with_read_off: addr12=5e");
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    mem_write = 1'b1;
    for (int i = 0; i < 8; i++) begin
      data_a = 8'(20 + i);
      data_b = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    mem_write = 1'b0;
    for (int i = 0; i < 8; i++) begin
      data_a = 8'(20 + i);
      #1;
      checks++;
      if (data_out !== 8'(8'h30 + i)) begin
        errors++;
        $display("FAIL b2b addr=%0d got=%h exp=%h", 20 + i, data_out, 8'(8'h30 + i));
      end
    end
    $display("test_back_to_back: addr20..27 written on consecutive edges");
  endtask

  task automatic test_async_reset;
    do_write(8'd4, 8'hA5);
    @(negedge clk);
    data_a = 8'd4; mem_read = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'hA5) begin
      errors++; $display("FAIL pre_reset_4 got=%h exp=a5", data_out);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL async_reset_4 got=%h exp=00", data_out);
    end
    data_a = 8'd10; #0.5;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL async_reset_10 got=%h exp=00", data_out);
    end
    reset = 1'b1;
    $display("test_async_reset: mid-cycle pulse cleared memory");
  endtask

  task automatic test_reset_vs_write;
    @(negedge clk);
    data_a = 8'd14; data_b = 8'h99; mem_write = 1'b1;
    #2 reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL write_during_reset got=%h exp=00", data_out);
    end
    @(negedge clk);
    mem_write = 1'b0;
    reset = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++; $display("FAIL reset_wins got=%h exp=00", data_out);
    end
    do_write(8'd14, 8'h77);
    checks++;
    if (data_out !== 8'h77) begin
      errors++; $display("FAIL first_write_after_reset got=%h exp=77", data_out);
    end
    $display("test_reset_vs_write: addr14 reset wins, then 77 accepted");
  endtask

  task automatic test_out_of_range;
    logic [7:0] model [0:199];
    for (int i = 0; i < 200; i++) model[i] = 8'h00;
    mem_read2 = 1'b1;
    do_write2(8'd0, 8'h5A);   model[0] = 8'h5A;
    do_write2(8'd199, 8'h66); model[199] = 8'h66;
    do_write2(8'd250, 8'h55);
    do_write2(8'd200, 8'hC3);
    data_a2 = 8'd250; #1;
    checks++;
    if (data_out2 !== 8'h00) begin
      errors++; $display("FAIL oor_read_250 got=%h exp=00", data_out2);
    end
    data_a2 = 8'd200; #1;
    checks++;
    if (data_out2 !== 8'h00) begin
      errors++; $display("FAIL oor_read_200 got=%h exp=00", data_out2);
    end
    for (int a = 0; a < 200; a++) begin
      data_a2 = 8'(a);
      #1;
      checks++;
      if (data_out2 !== model[a]) begin
        errors++;
        $display("FAIL oor_sweep addr=%0d got=%h exp=%h", a, data_out2, model[a]);
      end
    end
    $display("test_out_of_range: writes to 250/200 ignored, 0..199 intact");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    data_a = '0; mem_read = 1'b1; mem_write = 1'b0; data_b = '0;
    data_a2 = '0; mem_read2 = 1'b1; mem_write2 = 1'b0; data_b2 = '0;
    #1 reset = 1'b0;
    #1 reset = 1'b1;
    test_reset;
    test_write_readback;
    test_write_disabled;
    test_backdoor;
    test_read_during_write;
    test_write_with_read_off;
    test_back_to_back;
    test_async_reset;
    test_reset_vs_write;
    test_out_of_range;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
